datapath_seq_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences the register-file/ALU/immediate-select datapath.
- Fetches 32-bit instructions over a req/ack handshake and holds the program counter.
- Decodes a fixed RV32I subset (ADDI, ADD, BEQ, BNE) and drives rs1/rs2/rd/ImmOp/ALUsrc/RegWrite into the datapath.
- Consumes the datapath EQ flag to resolve branches.

---
 rtl/datapath_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_datapath_seq_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/datapath_seq_ctrl.sv
// datapath_seq_ctrl: multi-cycle fetch/decode/exec sequencer for an ADDI/ADD/BEQ/BNE datapath.
// Optional macro CTRL_RETIRE_CNT_EN adds a retired-instruction counter output.
module datapath_seq_ctrl #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic                     instr_req,
   output logic [DATA_WIDTH-1:0]    instr_addr,
   input  logic                     instr_ack,
   input  logic [DATA_WIDTH-1:0]    instr,
   input  logic                     EQ,
   output logic                     RegWrite,
   output logic                     ALUsrc,
   output logic [ADDRESS_WIDTH-1:0] rs1,
   output logic [ADDRESS_WIDTH-1:0] rs2,
   output logic [ADDRESS_WIDTH-1:0] rd,
   output logic [DATA_WIDTH-1:0]    ImmOp,
`ifdef CTRL_RETIRE_CNT_EN
   output logic [DATA_WIDTH-1:0]    retired,
`endif
   output logic                     busy,
   output logic                     illegal
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;
   typedef enum logic [1:0] {OP_ALU, OP_BEQ, OP_BNE} op_t;
   state_t state_q, state_d;
   op_t op_q, op_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d, instr_q, instr_d, imm_q, imm_d, target;
   logic [ADDRESS_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic alusrc_q, alusrc_d, illegal_q, illegal_d, is_addi, is_add, is_br, taken, retire;
`ifdef CTRL_RETIRE_CNT_EN
   logic [DATA_WIDTH-1:0] retired_q, retired_d;
`endif
   assign is_addi = instr_q[6:0] == 7'b0010011 && instr_q[14:12] == 3'b000;
   assign is_add = instr_q[6:0] == 7'b0110011 && instr_q[14:12] == 3'b000 && instr_q[31:25] == 7'b0;
   assign is_br = instr_q[6:0] == 7'b1100011 && instr_q[14:13] == 2'b00;
   assign taken = op_q == OP_BEQ ? EQ : op_q == OP_BNE ? !EQ : 1'b0;
   assign target = pc_q + imm_q;
   always_comb begin
      state_d = state_q;
      op_d = op_q;
      pc_d = pc_q;
      instr_d = instr_q;
      imm_d = imm_q;
      rs1_d = rs1_q;
      rs2_d = rs2_q;
      rd_d = rd_q;
      alusrc_d = alusrc_q;
      illegal_d = illegal_q;
      retire = 1'b0;
      case (state_q)
         IDLE: state_d = start ? FETCH : IDLE;
         FETCH: begin
            instr_d = instr_ack ? instr : instr_q;
            state_d = instr_ack ? DECODE : FETCH;
         end
         DECODE: begin
            rs1_d = instr_q[15 +: ADDRESS_WIDTH];
            rs2_d = instr_q[20 +: ADDRESS_WIDTH];
            rd_d = instr_q[7 +: ADDRESS_WIDTH];
            alusrc_d = is_addi;
            op_d = !is_br ? OP_ALU : instr_q[12] ? OP_BNE : OP_BEQ;
            imm_d = is_addi ? {{(DATA_WIDTH-12){instr_q[31]}}, instr_q[31:20]}
                  : is_br ? {{(DATA_WIDTH-13){instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0}
                  : '0;
            state_d = is_addi || is_add || is_br ? EXEC : HALT;
            illegal_d = !(is_addi || is_add || is_br);
         end
         EXEC: begin
            // a taken branch to a non-word-aligned target aborts without moving the PC
            illegal_d = taken && target[1:0] != 2'b00;
            state_d = illegal_d ? HALT : FETCH;
            pc_d = illegal_d ? pc_q : taken ? target : pc_q + DATA_WIDTH'(4);
            retire = !illegal_d;
         end
         default: state_d = HALT;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q <= OP_ALU;
         pc_q <= RESET_PC;
         instr_q <= '0;
         imm_q <= '0;
         rs1_q <= '0;
         rs2_q <= '0;
         rd_q <= '0;
         alusrc_q <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q <= op_d;
         pc_q <= pc_d;
         instr_q <= instr_d;
         imm_q <= imm_d;
         rs1_q <= rs1_d;
         rs2_q <= rs2_d;
         rd_q <= rd_d;
         alusrc_q <= alusrc_d;
         illegal_q <= illegal_d;
      end
   end
`ifdef CTRL_RETIRE_CNT_EN
   assign retired_d = retire ? retired_q + DATA_WIDTH'(1) : retired_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) retired_q <= '0;
      else retired_q <= retired_d;
   end
   assign retired = retired_q;
`endif
   assign instr_req = state_q == FETCH;
   assign instr_addr = pc_q;
   assign RegWrite = state_q == EXEC && op_q == OP_ALU && rd_q != '0;
   assign ALUsrc = alusrc_q;
   assign rs1 = rs1_q;
   assign rs2 = rs2_q;
   assign rd = rd_q;
   assign ImmOp = imm_q;
   assign busy = state_q == FETCH || state_q == DECODE || state_q == EXEC;
   assign illegal = illegal_q;
endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// tb_datapath_seq_ctrl: directed-vector bench for datapath_seq_ctrl; drives and samples on the falling edge.
module tb_datapath_seq_ctrl;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, instr_ack = 1'b0, EQ = 1'b0;
   logic [31:0] instr = '0;
   logic instr_req, RegWrite, ALUsrc, busy, illegal;
   logic [31:0] instr_addr, ImmOp;
   logic [4:0] rs1, rs2, rd;
`ifdef CTRL_RETIRE_CNT_EN
   logic [31:0] retired;
`endif
   int n_pass = 0, n_tot = 0;
   datapath_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .instr_req(instr_req), .instr_addr(instr_addr),
      .instr_ack(instr_ack), .instr(instr), .EQ(EQ), .RegWrite(RegWrite), .ALUsrc(ALUsrc),
      .rs1(rs1), .rs2(rs2), .rd(rd), .ImmOp(ImmOp),
`ifdef CTRL_RETIRE_CNT_EN
      .retired(retired),
`endif
      .busy(busy), .illegal(illegal)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else n_pass++;
   endtask
   task automatic step();
      @(negedge clk);
   endtask
   // entered in FETCH at pc; returns at the negedge after DECODE (EXEC or HALT)
   task automatic run(input logic [31:0] iw, input logic [31:0] pc, input int w, input logic eq);
      chk("fetch_req", 32'(instr_req), 32'd1);
      chk("fetch_addr", instr_addr, pc);
      for (int i = 0; i < w; i++) begin
         instr_ack = 1'b0;
         instr = 32'hDEAD_BEEF;
         step();
         chk("wait_req", 32'(instr_req), 32'd1);
         chk("wait_addr", instr_addr, pc);
      end
      instr_ack = 1'b1;
      instr = iw;
      step();
      instr_ack = 1'b0;
      instr = 32'hDEAD_BEEF;
      chk("dec_rw", 32'(RegWrite), 32'd0);
      EQ = eq;
      step();
   endtask
   task automatic reset_start();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask
   initial begin
      step();
      step();
      chk("rst_req", 32'(instr_req), 32'd0);
      chk("rst_addr", instr_addr, 32'd0);
      chk("rst_rw", 32'(RegWrite), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ill", 32'(illegal), 32'd0);
      chk("rst_imm", ImmOp, 32'd0);
      chk("rst_src", 32'(ALUsrc), 32'd0);
      chk("rst_rd", 32'(rd), 32'd0);
      rst_n = 1'b1;
      step();
      chk("idle_req", 32'(instr_req), 32'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      run(32'h0070_0293, 32'd0, 0, 1'b0);
      chk("addi_rs1", 32'(rs1), 32'd0);
      chk("addi_rd", 32'(rd), 32'd5);
      chk("addi_imm", ImmOp, 32'd7);
      chk("addi_src", 32'(ALUsrc), 32'd1);
      chk("addi_rw", 32'(RegWrite), 32'd1);
      step();
      chk("addi_rw_off", 32'(RegWrite), 32'd0);
      run(32'h0020_8033, 32'd4, 0, 1'b0);
      chk("add_rw", 32'(RegWrite), 32'd0);
      chk("add_src", 32'(ALUsrc), 32'd0);
      chk("add_imm", ImmOp, 32'd0);
      chk("add_rs1", 32'(rs1), 32'd1);
      chk("add_rs2", 32'(rs2), 32'd2);
      step();
      run(32'hFE20_9CE3, 32'd8, 0, 1'b0);
      chk("bne_imm", ImmOp, 32'hFFFF_FFF8);
      chk("bne_rw", 32'(RegWrite), 32'd0);
      step();
      run(32'h0020_8033, 32'd0, 0, 1'b0);
      step();
      run(32'h0020_8033, 32'd4, 0, 1'b0);
      step();
      run(32'hFE20_9CE3, 32'd8, 0, 1'b1);
      step();
      run(32'h0000_0000, 32'd12, 0, 1'b0);
      chk("ill_flag", 32'(illegal), 32'd1);
      chk("ill_busy", 32'(busy), 32'd0);
      chk("ill_req", 32'(instr_req), 32'd0);
      chk("ill_addr", instr_addr, 32'd12);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("halt_req", 32'(instr_req), 32'd0);
      chk("halt_busy", 32'(busy), 32'd0);
      chk("halt_ill", 32'(illegal), 32'd1);
      reset_start();
      chk("rst_clr_ill", 32'(illegal), 32'd0);
      run(32'h0070_0293, 32'd0, 3, 1'b0);
      chk("dly_rw", 32'(RegWrite), 32'd1);
      step();
      run(32'h0070_0293, 32'd4, 0, 1'b0);
      step();
`ifdef CTRL_RETIRE_CNT_EN
      chk("ret_two", retired, 32'd2);
`endif
      run(32'h0070_0293, 32'd8, 0, 1'b0);
      chk("mid_rw_pre", 32'(RegWrite), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rw", 32'(RegWrite), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_addr", instr_addr, 32'd0);
      step();
      chk("mid_req", 32'(instr_req), 32'd0);
`ifdef CTRL_RETIRE_CNT_EN
      chk("ret_rst", retired, 32'd0);
`endif
      reset_start();
      run(32'hFFF0_0093, 32'd0, 0, 1'b0);
      chk("neg_imm", ImmOp, 32'hFFFF_FFFF);
      chk("neg_rd", 32'(rd), 32'd1);
      step();
      run(32'h0000_0163, 32'd4, 1, 1'b1);
      chk("mis_imm", ImmOp, 32'd2);
      step();
      chk("mis_ill", 32'(illegal), 32'd1);
      chk("mis_busy", 32'(busy), 32'd0);
      chk("mis_addr", instr_addr, 32'd4);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
